// File: rtl/bcd_counter_mod.sv
// Multi-digit BCD up/down counter with programmable modulus, parallel load and 7-segment decode.
// done is the terminal-count carry that enables the next stage in a cascade.
`timescale 1ns/1ps
module bcd_counter_mod #(
  parameter int DIGITS    = 2,
  parameter int MODULUS   = 60,
  parameter int RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                done,
  output logic                load_err
);
  localparam int W = 4 * DIGITS;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    int r;
    b = '0;
    r = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_counter_mod: DIGITS=%0d outside 1..4", DIGITS);
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_counter_mod: MODULUS=%0d outside 2..10^DIGITS", MODULUS);
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("bcd_counter_mod: RESET_VAL=%0d not below MODULUS", RESET_VAL);
  end

  localparam logic [15:0]  MAX_BCD16 = to_bcd(MODULUS - 1);
  localparam logic [15:0]  RST_BCD16 = to_bcd(RESET_VAL);
  localparam logic [W-1:0] MAX_BCD   = MAX_BCD16[W-1:0];
  localparam logic [W-1:0] RST_BCD   = RST_BCD16[W-1:0];

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         carry;
  logic         borrow;
  logic         nibbles_ok;
  logic         load_ok;
  logic         at_max;
  logic         at_zero;

  always_comb begin
    inc_val    = count_bcd;
    dec_val    = count_bcd;
    carry      = 1'b1;
    borrow     = 1'b1;
    nibbles_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_bcd[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) nibbles_ok = 1'b0;
    end
  end

  // With every nibble a legal digit, packed-BCD ordering equals decimal ordering.
  assign load_ok = nibbles_ok && (load_val <= MAX_BCD);
  assign at_max  = (count_bcd == MAX_BCD);
  assign at_zero = (count_bcd == '0);
  assign done    = enable & ~reset & ((up & at_max) | (~up & at_zero));

  always_ff @(posedge clk) begin
    if (reset) begin
      count_bcd <= RST_BCD;
      load_err  <= 1'b0;
    end else if (load) begin
      if (load_ok) count_bcd <= load_val;
      load_err <= ~load_ok;
    end else begin
      load_err <= 1'b0;
      if (enable) begin
        if (up) count_bcd <= at_max ? '0 : inc_val;
        else    count_bcd <= at_zero ? MAX_BCD : dec_val;
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) seg[7*i +: 7] = seg7(count_bcd[4*i +: 4]);
  end

endmodule

// File: doc/bcd_counter_mod.md
Name: bcd_counter_mod

Overview:
- Parametrised multi-digit BCD counter with programmable modulus, up/down direction, synchronous parallel load and per-digit 7-segment outputs.
- Generalises the single-digit 0-9 stage used in the clock chain, so one block serves seconds/minutes (mod 60), hours (mod 24), days, years (mod 100) and similar.
- Stages cascade by driving the next stage's enable from this stage's done.

Parameters:
- DIGITS, 2, number of BCD digits; legal 1..4.
- MODULUS, 60, count range is 0..MODULUS-1; legal 2..10^DIGITS.
- RESET_VAL, 0, value loaded on reset as an integer; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  count tick or cascade carry-in; one step per cycle while high.
- up  input  1  direction: 1 counts up, 0 counts down; sampled each enabled cycle.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  BCD load value; digit 0 is bits [3:0].
- count_bcd  output  4*DIGITS  registered current value in BCD.
- seg  output  7*DIGITS  7-segment pattern per digit; digit i is bits [7i+6:7i]; bit0=a .. bit6=g; active-high.
- done  output  1  combinational terminal-count carry to the next stage.
- load_err  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- One clock domain; reset is synchronous and active-high, ports named clk and reset.
- Priority per rising edge: reset > load > enable > hold.
- Reset:
  - count_bcd = RESET_VAL in BCD; load_err = 0.
  - done follows from the reset count, and is 0 while enable is low.
- Load:
  - Valid when every nibble of load_val is <= 9 and the decimal value is < MODULUS.
  - Valid: count_bcd = load_val on the next edge; load_err = 0.
  - Invalid: count holds; load_err = 1 for exactly one cycle.
  - While load is high, enable is ignored that cycle, including a coincident terminal count. done is still evaluated from the current count.
- Count up (enable=1, up=1):
  - Count = MODULUS-1: next = 0.
  - Otherwise: BCD increment; a digit at 9 goes to 0 and carries into the next digit.
- Count down (enable=1, up=0):
  - Count = 0: next = MODULUS-1.
  - Otherwise: BCD decrement; a digit at 0 goes to 9 and borrows from the next digit.
- Hold (enable=0, no load): count unchanged.
- done, combinational:
  - done = enable & ~reset & ((up & count==MODULUS-1) | (~up & count==0)).
  - It is high during the cycle that wraps, so a downstream stage steps on the same edge.
- Latency: count_bcd updates 1 cycle after the qualifying edge; seg is a combinational decode of count_bcd, so 0 extra cycles.
- Segment decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex, {g..a}).
  - Nibbles >9 cannot occur in normal operation; decode them to 00.
- Direction change mid-count takes effect on the next enabled edge; there is no internal state beyond the count.
- Reset asserted mid-count or with load/enable high: reset wins, and count = RESET_VAL next cycle.
- Illegal parameters (MODULUS out of range, RESET_VAL >= MODULUS) are flagged at elaboration; runtime behaviour is undefined.
- Comparisons are on the BCD value. Constants MODULUS-1 and RESET_VAL are converted to BCD at elaboration; there is no binary-to-BCD logic at runtime.

Test Plan:
- DIGITS=2, MODULUS=60: reset, then 60 enabled cycles with up=1 -> counts 00..59. done=1 only while count=59, then count=00.
- DIGITS=2, MODULUS=24, count=00, up=0, enable=1 -> next count=23. done=1 in the cycle at 00; next steps are 22, 21.
- Load 0x45 with MODULUS=60 -> count=45, load_err=0. Load 0x61 -> count holds, load_err=1 for one cycle. Load 0x3A -> rejected, load_err=1.
- load=1 and enable=1 together at count=59 -> count=load_val. Reset=1 with load=1 -> count=RESET_VAL.
- Two instances cascaded (mod 60 seconds feeding mod 60 minutes via done->enable) from 00:59 -> 01:00 on one edge. From 59:59 -> 00:00, with minutes done=1 in that cycle.
- DIGITS=1, MODULUS=10: count 0..9 -> seg = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. enable=0 holds the count and done=0.
